// File: rtl/cpu_pkg.sv
// Shared opcode and ALU-operation constants for the CPU pipeline.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;

  // Non-zero encodings so a decoded op is distinguishable from a cleared bundle
  localparam logic [3:0] ALUOP_ADD  = 4'h1;
  localparam logic [3:0] ALUOP_COMP = 4'h2;

endpackage

// File: rtl/cpu_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// producer issues and cleared on writeback. Source queries see a register being
// written back this cycle as already free.
module cpu_scoreboard
  import cpu_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_en,
  input  logic [REG_AW-1:0] set_reg,
  input  logic              clr_en,
  input  logic [REG_AW-1:0] clr_reg,
  input  logic              q1_used,
  input  logic [REG_AW-1:0] q1_reg,
  input  logic              q2_used,
  input  logic [REG_AW-1:0] q2_reg,
  output logic              busy1,
  output logic              busy2
);

  localparam int NUM_REGS = 2 ** REG_AW;

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  // One-hot set/clear masks for this cycle's issue and writeback
  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en) set_mask[set_reg] = 1'b1;
    if (clr_en) clr_mask[clr_reg] = 1'b1;
  end

  // Clear first, then set, so a same-cycle set of the same register wins
  always_ff @(posedge clk) begin
    if (!rst_n) pending <= '0;
    else        pending <= (pending & ~clr_mask) | set_mask;
  end

  assign busy1 = q1_used && (q1_reg != '0) && pending[q1_reg] && !(clr_en && (clr_reg == q1_reg));
  assign busy2 = q2_used && (q2_reg != '0) && pending[q2_reg] && !(clr_en && (clr_reg == q2_reg));

endmodule

// File: rtl/cpu_decode_stage.sv
// Registered instruction-decode stage: decodes the fetched word into the
// execute control bundle, stalls fetch on read-after-write hazards, honours a
// branch flush and counts hazard-stall cycles.
module cpu_decode_stage
  import cpu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter bit SIGN_EXT_IMM = 1'b1,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [31:0]       if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_ready,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [XLEN-1:0]   id_pc,
  output logic [REG_AW-1:0] src_reg1,
  output logic [REG_AW-1:0] src_reg2,
  output logic [REG_AW-1:0] dst_reg,
  output logic              src1_used,
  output logic              src2_used,
  output logic [XLEN-1:0]   immediate_value,
  output logic              immediate,
  output logic              do_jump,
  output logic              alu_jump,
  output logic              branch_eq,
  output logic [XLEN-1:0]   jump_address,
  output logic [3:0]        aluop,
  output logic              write_enable,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_reg,
  input  logic              flush,
  output logic [CNT_W-1:0]  stall_count
);

  typedef struct packed {
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [REG_AW-1:0] dst;
    logic              src1_used;
    logic              src2_used;
    logic [XLEN-1:0]   imm_val;
    logic              imm;
    logic              do_jump;
    logic              alu_jump;
    logic              branch_eq;
    logic [XLEN-1:0]   jaddr;
    logic [3:0]        aluop;
    logic              we;
  } dec_t;

  function automatic logic [XLEN-1:0] ext_imm(input logic [15:0] imm16);
    if (SIGN_EXT_IMM) return XLEN'($signed(imm16));
    else              return XLEN'(imm16);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t d;
    logic [5:0] opcode;
    d      = '0;
    opcode = instr[31:26];
    case (opcode)
      OP_RTYPE: begin
        d.src1      = REG_AW'(instr[25:21]);
        d.src2      = REG_AW'(instr[20:16]);
        d.dst       = REG_AW'(instr[15:11]);
        d.src1_used = 1'b1;
        d.src2_used = 1'b1;
        d.aluop     = ALUOP_ADD;
        d.we        = 1'b1;
      end
      OP_J: begin
        d.do_jump = 1'b1;
        d.jaddr   = XLEN'(instr[25:0]);
      end
      OP_BEQ, OP_BNE: begin
        d.src1      = REG_AW'(instr[25:21]);
        d.src2      = REG_AW'(instr[20:16]);
        d.src1_used = 1'b1;
        d.src2_used = 1'b1;
        d.do_jump   = 1'b1;
        d.alu_jump  = 1'b1;
        d.branch_eq = (opcode == OP_BEQ);
        d.aluop     = ALUOP_COMP;
        d.jaddr     = XLEN'(instr[15:0]);
      end
      default: begin
        d.src1      = REG_AW'(instr[25:21]);
        d.dst       = REG_AW'(instr[20:16]);
        d.src1_used = 1'b1;
        d.imm       = 1'b1;
        d.imm_val   = ext_imm(instr[15:0]);
        d.aluop     = ALUOP_ADD;
        d.we        = 1'b1;
      end
    endcase
    // r0 is hard-wired zero, so a write to it is dropped
    if (d.dst == '0) d.we = 1'b0;
    return d;
  endfunction

  dec_t              dec_in;
  dec_t              bundle_p1;
  logic              vld_p1;
  logic [XLEN-1:0]   pc_p1;
  logic [CNT_W-1:0]  stall_cnt;
  logic              sb_busy1;
  logic              sb_busy2;
  logic              held_hit1;
  logic              held_hit2;
  logic              hazard;
  logic              accept;
  logic              issue;

  assign dec_in = decode(if_instr);

  // The held bundle has not issued yet, so it is invisible to the scoreboard
  assign held_hit1 = vld_p1 && bundle_p1.we && dec_in.src1_used && (bundle_p1.dst == dec_in.src1);
  assign held_hit2 = vld_p1 && bundle_p1.we && dec_in.src2_used && (bundle_p1.dst == dec_in.src2);
  assign hazard    = if_valid && (sb_busy1 || sb_busy2 || held_hit1 || held_hit2);

  assign if_ready = rst_n && (!vld_p1 || id_ready) && !hazard && !flush;
  assign accept   = if_valid && if_ready;
  assign issue    = vld_p1 && id_ready && bundle_p1.we && !flush;

  cpu_scoreboard #(
    .REG_AW (REG_AW)
  ) u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (issue),
    .set_reg (bundle_p1.dst),
    .clr_en  (wb_valid),
    .clr_reg (wb_reg),
    .q1_used (dec_in.src1_used),
    .q1_reg  (dec_in.src1),
    .q2_used (dec_in.src2_used),
    .q2_reg  (dec_in.src2),
    .busy1   (sb_busy1),
    .busy2   (sb_busy2)
  );

  // Stage p1: decoded bundle register, valid tracking and stall counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_p1    <= 1'b0;
      bundle_p1 <= '0;
      pc_p1     <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) begin
        vld_p1 <= 1'b0;
      end else if (accept) begin
        vld_p1    <= 1'b1;
        bundle_p1 <= dec_in;
        pc_p1     <= if_pc;
      end else if (id_ready) begin
        vld_p1 <= 1'b0;
      end
      if (hazard && !flush) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign id_valid        = vld_p1;
  assign id_pc           = pc_p1;
  assign src_reg1        = bundle_p1.src1;
  assign src_reg2        = bundle_p1.src2;
  assign dst_reg         = bundle_p1.dst;
  assign src1_used       = bundle_p1.src1_used;
  assign src2_used       = bundle_p1.src2_used;
  assign immediate_value = bundle_p1.imm_val;
  assign immediate       = bundle_p1.imm;
  assign do_jump         = bundle_p1.do_jump;
  assign alu_jump        = bundle_p1.alu_jump;
  assign branch_eq       = bundle_p1.branch_eq;
  assign jump_address    = bundle_p1.jaddr;
  assign aluop           = bundle_p1.aluop;
  assign write_enable    = bundle_p1.we;
  assign stall_count     = stall_cnt;

endmodule

// File: tb/tb_cpu_decode_stage.sv
// Testbench for cpu_decode_stage: two instances (sign- and zero-extending
// immediates) share stimulus; a spec-level model is compared every cycle and
// directed checks pin hand-computed values.
module tb_cpu_decode_stage;
  import cpu_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [4:0]  s1;
    logic [4:0]  s2;
    logic [4:0]  d;
    logic        u1;
    logic        u2;
    logic [31:0] iv;
    logic        im;
    logic        dj;
    logic        aj;
    logic        beq;
    logic [31:0] ja;
    logic [3:0]  op;
    logic        we;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n, if_valid, id_ready, wb_valid, flush;
  logic [31:0] if_instr, if_pc;
  logic [4:0]  wb_reg;

  logic if_ready, id_valid, src1_used, src2_used, immediate, do_jump, alu_jump, branch_eq, write_enable;
  logic [31:0] id_pc, immediate_value, jump_address;
  logic [4:0] src_reg1, src_reg2, dst_reg;
  logic [3:0] aluop;
  logic [CNT_W-1:0] stall_count;

  logic b_if_ready, b_id_valid, b_src1_used, b_src2_used, b_immediate, b_do_jump, b_alu_jump, b_branch_eq, b_write_enable;
  logic [31:0] b_id_pc, b_immediate_value, b_jump_address;
  logic [4:0] b_src_reg1, b_src_reg2, b_dst_reg;
  logic [3:0] b_aluop;
  logic [CNT_W-1:0] b_stall_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cpu_decode_stage #(.XLEN(32), .REG_AW(5), .SIGN_EXT_IMM(1'b1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(if_ready), .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
    .src_reg1(src_reg1), .src_reg2(src_reg2), .dst_reg(dst_reg),
    .src1_used(src1_used), .src2_used(src2_used), .immediate_value(immediate_value),
    .immediate(immediate), .do_jump(do_jump), .alu_jump(alu_jump), .branch_eq(branch_eq),
    .jump_address(jump_address), .aluop(aluop), .write_enable(write_enable),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush), .stall_count(stall_count)
  );

  cpu_decode_stage #(.XLEN(32), .REG_AW(5), .SIGN_EXT_IMM(1'b0), .CNT_W(CNT_W)) dut_z (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_ready(b_if_ready), .id_valid(b_id_valid), .id_ready(id_ready), .id_pc(b_id_pc),
    .src_reg1(b_src_reg1), .src_reg2(b_src_reg2), .dst_reg(b_dst_reg),
    .src1_used(b_src1_used), .src2_used(b_src2_used), .immediate_value(b_immediate_value),
    .immediate(b_immediate), .do_jump(b_do_jump), .alu_jump(b_alu_jump), .branch_eq(b_branch_eq),
    .jump_address(b_jump_address), .aluop(b_aluop), .write_enable(b_write_enable),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush), .stall_count(b_stall_count)
  );

  exp_t act_a, act_b;
  assign act_a = {src_reg1, src_reg2, dst_reg, src1_used, src2_used, immediate_value, immediate,
                  do_jump, alu_jump, branch_eq, jump_address, aluop, write_enable};
  assign act_b = {b_src_reg1, b_src_reg2, b_dst_reg, b_src1_used, b_src2_used, b_immediate_value, b_immediate,
                  b_do_jump, b_alu_jump, b_branch_eq, b_jump_address, b_aluop, b_write_enable};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_bundle(input string tag, input exp_t a, input exp_t e);
    chk({tag, ".src_reg1"}, a.s1, e.s1);
    chk({tag, ".src_reg2"}, a.s2, e.s2);
    chk({tag, ".dst_reg"}, a.d, e.d);
    chk({tag, ".src_used"}, {a.u1, a.u2}, {e.u1, e.u2});
    chk({tag, ".immediate_value"}, a.iv, e.iv);
    chk({tag, ".imm/jump/alu_jump/beq"}, {a.im, a.dj, a.aj, a.beq}, {e.im, e.dj, e.aj, e.beq});
    chk({tag, ".jump_address"}, a.ja, e.ja);
    chk({tag, ".aluop"}, a.op, e.op);
    chk({tag, ".write_enable"}, a.we, e.we);
  endtask

  // What the decoded bundle must be for an instruction word, straight from the field rules
  function automatic exp_t model_decode(input logic [31:0] w, input bit sext);
    exp_t e;
    int unsigned opc, rs, rt, rd, imm;
    e   = '0;
    opc = w >> 26;
    rs  = (w >> 21) & 31;
    rt  = (w >> 16) & 31;
    rd  = (w >> 11) & 31;
    imm = w & 32'hFFFF;
    if (opc == 0) begin
      e.s1 = 5'(rs); e.s2 = 5'(rt); e.d = 5'(rd); e.u1 = 1'b1; e.u2 = 1'b1;
      e.op = ALUOP_ADD; e.we = (rd != 0);
    end else if (opc == 2) begin
      e.dj = 1'b1; e.ja = w & 32'h03FF_FFFF;
    end else if (opc == 4 || opc == 5) begin
      e.s1 = 5'(rs); e.s2 = 5'(rt); e.u1 = 1'b1; e.u2 = 1'b1;
      e.dj = 1'b1; e.aj = 1'b1; e.beq = (opc == 4); e.op = ALUOP_COMP; e.ja = imm;
    end else begin
      e.s1 = 5'(rs); e.u1 = 1'b1; e.d = 5'(rt); e.im = 1'b1; e.op = ALUOP_ADD;
      e.we = (rt != 0);
      e.iv = (sext && imm >= 32768) ? imm + 32'hFFFF_0000 : imm;
    end
    return e;
  endfunction

  // Model state
  bit          m_init = 1'b0;
  bit          m_valid, m_fresh;
  exp_t        m_a, m_b;
  logic [31:0] m_pc;
  bit          m_pend [32];
  int          m_cnt;

  // Per-cycle comparison against the model, then prediction of the next edge
  always @(negedge clk) begin
    exp_t cur;
    bit haz, rdy, issue;
    cur = model_decode(if_instr, 1'b1);
    haz = 1'b0;
    if (if_valid === 1'b1) begin
      if (cur.u1 && cur.s1 != 0 &&
          ((m_pend[cur.s1] && !(wb_valid && wb_reg == cur.s1)) || (m_valid && m_a.we && m_a.d == cur.s1)))
        haz = 1'b1;
      if (cur.u2 && cur.s2 != 0 &&
          ((m_pend[cur.s2] && !(wb_valid && wb_reg == cur.s2)) || (m_valid && m_a.we && m_a.d == cur.s2)))
        haz = 1'b1;
    end
    rdy = rst_n && (!m_valid || id_ready) && !haz && !flush;
    if (m_init) begin
      chk("if_ready", if_ready, rdy);
      chk("z.if_ready", b_if_ready, rdy);
      chk("id_valid", id_valid, m_valid);
      chk("z.id_valid", b_id_valid, m_valid);
      chk("stall_count", stall_count, m_cnt);
      chk("z.stall_count", b_stall_count, m_cnt);
      if (m_valid || m_fresh) begin
        chk("id_pc", id_pc, m_pc);
        chk("z.id_pc", b_id_pc, m_pc);
        chk_bundle("s", act_a, m_a);
        chk_bundle("z", act_b, m_b);
      end
    end
    if (!rst_n) begin
      m_init = 1'b1; m_valid = 1'b0; m_fresh = 1'b1;
      m_a = '0; m_b = '0; m_pc = '0; m_cnt = 0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
    end else if (m_init) begin
      issue = m_valid && id_ready && m_a.we && !flush;
      if (wb_valid) m_pend[wb_reg] = 1'b0;
      if (issue) m_pend[m_a.d] = 1'b1;
      if (haz && !flush && m_cnt < CNT_MAX) m_cnt++;
      if (flush) m_valid = 1'b0;
      else if (if_valid && rdy) begin
        m_valid = 1'b1; m_fresh = 1'b0; m_pc = if_pc;
        m_a = cur; m_b = model_decode(if_instr, 1'b0);
      end else if (id_ready) m_valid = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and hold it until the stage takes it (bounded)
  task automatic send(input logic [31:0] w, input logic [31:0] pc);
    int n;
    if_instr = w; if_pc = pc; if_valid = 1'b1;
    #1;
    n = 0;
    while (!if_ready && n < 40) begin
      step();
      n++;
    end
    chk("send_accept", if_ready, 1'b1);
    step();
    if_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0;
    id_ready = 1'b1; wb_valid = 1'b0; wb_reg = '0; flush = 1'b0;
    repeat (3) step();
    chk("reset.id_valid", id_valid, 1'b0);
    chk("reset.stall_count", stall_count, 0);
    chk("reset.if_ready", if_ready, 1'b0);
    rst_n = 1'b1;
    step();

    // R-type add r3 = r1 + r2
    send(32'h0022_1800, 32'h100);
    chk("rtype.id_valid", id_valid, 1'b1);
    chk("rtype.regs", {src_reg1, src_reg2, dst_reg}, {5'd1, 5'd2, 5'd3});
    chk("rtype.we", write_enable, 1'b1);
    chk("rtype.aluop", aluop, ALUOP_ADD);
    chk("rtype.pc", id_pc, 32'h100);

    // addi r4 = r3 + 0xFFFC: stalls behind r3 until writeback bypass
    if_instr = 32'h2064_FFFC; if_pc = 32'h104; if_valid = 1'b1;
    #1;
    chk("raw.held_stall", if_ready, 1'b0);
    step();
    chk("raw.pending_stall", if_ready, 1'b0);
    step();
    step();
    chk("raw.stall_count3", stall_count, 3);
    wb_valid = 1'b1; wb_reg = 5'd3;
    #1;
    chk("raw.bypass_ready", if_ready, 1'b1);
    step();
    wb_valid = 1'b0; if_valid = 1'b0;
    chk("itype.sext_imm", immediate_value, 32'hFFFF_FFFC);
    chk("itype.zext_imm", b_immediate_value, 32'h0000_FFFC);
    chk("itype.imm_src2used", {immediate, src2_used}, 2'b10);
    chk("itype.dst", dst_reg, 5'd4);
    chk("itype.stall_hold", stall_count, 3);
    step();
    wb_valid = 1'b1; wb_reg = 5'd4;
    step();
    wb_valid = 1'b0;

    // Branches
    send(32'h1085_0010, 32'h108);
    chk("beq.jump", {do_jump, alu_jump, branch_eq}, 3'b111);
    chk("beq.jaddr", jump_address, 32'h10);
    chk("beq.we_dst", {write_enable, dst_reg}, 6'd0);
    chk("beq.aluop", aluop, ALUOP_COMP);
    send(32'h1485_0010, 32'h10C);
    chk("bne.jump", {do_jump, alu_jump, branch_eq}, 3'b110);
    send(32'h0800_0040, 32'h110);
    chk("j.jump", {do_jump, alu_jump}, 2'b10);
    chk("j.jaddr", jump_address, 32'h40);
    chk("j.used_we", {src1_used, src2_used, write_enable}, 3'b000);
    step();

    // Hold for three cycles, then flush
    id_ready = 1'b0;
    send(32'h2007_0005, 32'h114);
    chk("hold.dst", dst_reg, 5'd7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold.id_valid", id_valid, 1'b1);
      chk("hold.pc", id_pc, 32'h114);
      chk("hold.if_ready", if_ready, 1'b0);
    end
    flush = 1'b1; id_ready = 1'b1;
    #1;
    chk("flush.if_ready", if_ready, 1'b0);
    step();
    flush = 1'b0;
    chk("flush.id_valid", id_valid, 1'b0);
    if_instr = 32'h20E8_0001; if_pc = 32'h118; if_valid = 1'b1;
    #1;
    chk("flush.no_pending_r7", if_ready, 1'b1);
    step();
    if_valid = 1'b0;
    chk("flush.next_dst", dst_reg, 5'd8);
    step();

    // Writes to r0 are dropped and never stall readers
    send(32'h2020_0001, 32'h11C);
    chk("r0.we", {write_enable, dst_reg}, 6'd0);
    if_instr = 32'h0000_4800; if_pc = 32'h120; if_valid = 1'b1;
    #1;
    chk("r0.no_stall", if_ready, 1'b1);
    step();
    if_valid = 1'b0;
    chk("r0.reader", {dst_reg, write_enable}, {5'd9, 1'b1});

    // Saturate the stall counter behind a pending r10
    send(32'h200A_0001, 32'h124);
    if_instr = 32'h0140_5800; if_pc = 32'h128; if_valid = 1'b1;
    repeat (20) step();
    chk("sat.stall_count", stall_count, CNT_MAX);
    chk("sat.if_ready", if_ready, 1'b0);
    wb_valid = 1'b1; wb_reg = 5'd10;
    #1;
    chk("sat.release", if_ready, 1'b1);
    step();
    wb_valid = 1'b0; if_valid = 1'b0;
    chk("sat.hold", stall_count, CNT_MAX);
    step();

    // Reset while a bundle is held
    id_ready = 1'b0;
    send(32'h0022_1800, 32'h130);
    chk("midrst.pre_valid", id_valid, 1'b1);
    rst_n = 1'b0;
    step();
    chk("midrst.id_valid", id_valid, 1'b0);
    chk("midrst.clear", {stall_count, dst_reg, id_pc}, '0);
    rst_n = 1'b1; id_ready = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_decode_stage.md
Name: cpu_decode_stage

Overview:
- Registered instruction-decode pipeline stage between fetch and execute. Decodes R-type, J, BEQ, BNE and I-type instructions into the control bundle used by execute.
- Tracks in-flight destination registers in a scoreboard and stalls fetch on read-after-write hazards.
- Supports valid/ready handshakes on both sides, a branch flush, and a saturating stall counter for performance monitoring.

Parameters:
- XLEN, 32, datapath/address width of immediate_value, jump_address, pc.
- REG_AW, 5, register index width; NUM_REGS = 2**REG_AW.
- SIGN_EXT_IMM, 1, 1: I-type immediate sign-extended to XLEN; 0: zero-extended.
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous reset, active low.
- if_valid  in  1  fetch presents an instruction.
- if_instr  in  32  instruction word.
- if_pc  in  XLEN  PC of the instruction.
- if_ready  out  1  stage accepts if_instr this cycle.
- id_valid  out  1  decoded bundle valid.
- id_ready  in  1  execute consumes the bundle.
- id_pc  out  XLEN  PC of the held instruction.
- src_reg1, src_reg2, dst_reg  out  REG_AW each  register indices.
- src1_used, src2_used  out  1 each  source is read.
- immediate_value  out  XLEN  extended imm16.
- immediate  out  1  ALU operand B is the immediate.
- do_jump  out  1  control transfer.
- alu_jump  out  1  jump is conditional on the ALU compare.
- branch_eq  out  1  1: take branch if equal (BEQ); 0: take if not equal.
- jump_address  out  XLEN  target address.
- aluop  out  4  ALU operation.
- write_enable  out  1  writes dst_reg.
- wb_valid  in  1  writeback retires a register.
- wb_reg  in  REG_AW  retired register.
- flush  in  1  kill the held instruction and block accept.
- stall_count  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Fields: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], imm16=[15:0], target=[25:0]. Register fields are truncated or zero-padded to REG_AW.
- R-type (opcode 000000):
  - src1=rs, src2=rt, dst=rd; both sources used.
  - immediate=0, aluop=ALUOP_ADD, write_enable=1.
- J (000010):
  - do_jump=1, alu_jump=0.
  - jump_address = zero-extended target.
  - no sources used; dst=0; write_enable=0.
- BEQ (000100) / BNE (000101):
  - do_jump=1, alu_jump=1, aluop=ALUOP_COMP.
  - branch_eq = 1 for BEQ, 0 for BNE.
  - src1=rs, src2=rt, both used.
  - jump_address = zero-extended imm16.
  - write_enable=0, dst=0.
- Any other opcode is I-type:
  - src1=rs (used), src2=0 (unused), dst=rt.
  - immediate=1, aluop=ALUOP_ADD, write_enable=1.
  - immediate_value is extended per SIGN_EXT_IMM.
- Unused output fields are driven to 0, never X or Z.
- Register 0: a dst of 0 forces write_enable=0. A source of 0 never causes a hazard.
- Handshake:
  - if_ready = (!id_valid || id_ready) && !hazard && !flush.
  - On if_valid && if_ready, the bundle is registered next edge and id_valid=1. Latency is 1 cycle.
  - If id_valid && id_ready with no new accept, id_valid clears.
  - The bundle is held stable while id_valid && !id_ready.
- Scoreboard (NUM_REGS pending bits):
  - A bit is set for dst_reg when the held bundle issues (id_valid && id_ready && write_enable && !flush).
  - A bit is cleared on wb_valid for wb_reg.
  - Set and clear of the same register in the same cycle: set wins.
  - Writeback bypass: a register being cleared this cycle is treated as not pending for the hazard check.
- hazard = if_valid && a used incoming source S satisfies one of:
  - (pending[S] && !(wb_valid && wb_reg==S)), or
  - (id_valid && write_enable && dst_reg==S), i.e. the held, not-yet-issued producer.
- flush:
  - id_valid clears next edge, no issue occurs that cycle, and the scoreboard is not set. flush wins over id_ready.
  - Pending bits from already-issued instructions are kept.
- stall_count increments each cycle with if_valid && hazard && !flush. It saturates at all-ones.
- Reset (rst_n=0 at an edge):
  - id_valid=0, all decoded outputs=0, id_pc=0.
  - all pending bits=0, stall_count=0.
  - if_ready is 0 while rst_n=0. Reset mid-transfer drops the held instruction.

Decomposition:
- Shared package cpu_pkg: ALUOP_ADD, ALUOP_COMP, and the opcode constants OP_RTYPE, OP_J, OP_BEQ, OP_BNE.
- One sub-module, cpu_scoreboard: holds the pending bits, set/clear logic, and per-source hazard query with writeback bypass.
- Decode is a combinational function inside cpu_decode_stage.

Test Plan:
- Reset, then R-type add r3=r1+r2 (0x00221800) with id_ready=1 -> next cycle id_valid=1, src 1/2, dst 3, write_enable=1, aluop=ALUOP_ADD; pending[3]=1 after the issue edge.
- I-type with imm 0xFFFC, SIGN_EXT_IMM=1 -> immediate_value=0xFFFFFFFC, immediate=1, src2_used=0. With SIGN_EXT_IMM=0 -> 0x0000FFFC.
- Producer to r3, then consumer reading r3 with no writeback -> if_ready=0 and stall_count increments each cycle. wb_valid, wb_reg=3 -> accepted that same cycle via the bypass.
- BEQ rs=4 rt=5 imm=0x0010 -> do_jump=1, alu_jump=1, branch_eq=1, jump_address=0x10, write_enable=0. BNE gives branch_eq=0.
- Held bundle with id_ready=0 for 3 cycles, then flush=1 with id_ready=1 -> id_valid=0 next cycle, no pending bit set, if_ready=0 during the flush.
- Instruction with dst r0 issued, then a reader of r0 -> write_enable=0, no stall. Force stall_count to saturate -> it holds at 2**CNT_W-1.
